// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, the canonical NOP and the fetch FSM encoding.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT   = 3'd1,
        HOLD   = 3'd2,
        SQUASH = 3'd3,
        FAULT  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: one outstanding imem read, holds the returned
// word with its PC for the decoder, handles redirects and misaligned targets.
//
// state  | meaning
// -------+------------------------------------------------------------
// FETCH  | issue imem_req for pc (single-cycle pulse)
// WAIT   | request outstanding, waiting for imem_rvalid
// HOLD   | instr_out/pc_out presented, waiting for instr_ready
// SQUASH | request to a stale pc outstanding; drop its response
// FAULT  | misaligned redirect seen; frozen until rst
module instr_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            fetch_fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    // Next-state logic and the imem request; redirects take priority over
    // the normal per-state progression.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        fault_d  = fault_q;

        // Request is held off while rst is asserted, since memory is in reset too.
        imem_req  = (state_q == FETCH) && !rst;
        imem_addr = pc_q;

        if (state_q != FAULT) begin
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                fault_d = 1'b1;
                valid_d = 1'b0;
                pc_d    = redirect_pc;
                state_d = FAULT;
            end else if (redirect_valid) begin
                pc_d    = redirect_pc;
                valid_d = 1'b0;
                case (state_q)
                    FETCH:   state_d = SQUASH;
                    WAIT:    state_d = imem_rvalid ? FETCH : SQUASH;
                    HOLD:    state_d = FETCH;
                    // A response landing with the redirect retires the stale
                    // request; otherwise keep waiting for it.
                    SQUASH:  state_d = imem_rvalid ? FETCH : SQUASH;
                    default: state_d = state_q;
                endcase
            end else begin
                case (state_q)
                    FETCH: state_d = WAIT;
                    WAIT: begin
                        if (imem_rvalid) begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                            valid_d  = 1'b1;
                            state_d  = HOLD;
                        end
                    end
                    HOLD: begin
                        if (valid_q && instr_ready) begin
                            pc_d    = pc_q + XLEN'(4);
                            valid_d = 1'b0;
                            state_d = FETCH;
                        end
                    end
                    SQUASH: begin
                        if (imem_rvalid) begin
                            state_d = FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= RV_NOP;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main instance with a variable-latency
// memory, plus a second instance reset to the top word to exercise PC wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_rvalid;
    logic [31:0] w_instr;
    logic [31:0] w_pc_out;
    logic        w_valid;
    logic        w_fault;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          lat      = 1;
    int          cnt      = 0;
    logic [31:0] paddr;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .pc_out(pc_out),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fetch_fault(fetch_fault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .XLEN(32)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .imem_rvalid(w_rvalid),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_out(w_instr), .pc_out(w_pc_out),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .fetch_fault(w_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h003100B3;
            32'h4: return 32'h00500093;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    // Memory responder: one response per request, `lat` cycles later.
    always @(posedge clk) begin
        if (rst) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            cnt         <= 0;
        end else begin
            imem_rvalid <= 1'b0;
            if (imem_req) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(imem_addr);
                end else begin
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_word(paddr);
                end
            end
        end
    end

    // 1-cycle memory for the wrap instance.
    always @(posedge clk) begin
        w_rvalid <= rst ? 1'b0 : w_req;
        w_rdata  <= 32'h0000_0013;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max);
        int k = 0;
        while (!instr_valid && k < max) begin
            step();
            k++;
        end
        check(tag, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
    endtask

    initial begin
        int reqs;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;
        lat            = 1;

        // Reset state
        do_reset();
        check("rst_req",   {31'b0, imem_req},    32'd0);
        check("rst_instr", instr_out,            32'h0000_0013);
        check("rst_pc",    pc_out,               32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // Test 1: basic fetch with 1-cycle memory (cycle 0 after release)
        rst = 1'b0;
        #1;
        check("t1_c0_req",  {31'b0, imem_req}, 32'd1);
        check("t1_c0_addr", imem_addr,         32'h0);
        check("t6_c0_addr", w_addr,            32'hFFFF_FFFC);
        step(); // cycle 1
        check("t1_c1_req",  {31'b0, imem_req},    32'd0);
        check("t1_c1_valid",{31'b0, instr_valid}, 32'd0);
        step(); // cycle 2
        check("t1_c2_valid",{31'b0, instr_valid}, 32'd1);
        check("t1_c2_instr", instr_out,           32'h003100B3);
        check("t1_c2_pc",    pc_out,              32'h0);
        check("t6_c2_pc",    w_pc_out,            32'hFFFF_FFFC);
        step(); // cycle 3
        check("t1_c3_req",  {31'b0, imem_req}, 32'd1);
        check("t1_c3_addr", imem_addr,         32'h4);
        check("t6_wrap_req",  {31'b0, w_req},  32'd1);
        check("t6_wrap_addr", w_addr,          32'h0);
        step(); // cycle 4
        step(); // cycle 5
        check("t1_c5_valid",{31'b0, instr_valid}, 32'd1);
        check("t1_c5_pc",    pc_out,              32'h4);
        check("t1_c5_instr", instr_out,           32'h00500093);

        // Test 2: backpressure in HOLD
        instr_ready = 1'b0;
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req) reqs++;
            check("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
            check("t2_hold_pc",    pc_out,               32'h4);
            check("t2_hold_instr", instr_out,            32'h00500093);
        end
        check("t2_no_req", reqs, 32'd0);
        instr_ready = 1'b1;
        step();
        check("t2_next_req",  {31'b0, imem_req}, 32'd1);
        check("t2_next_addr", imem_addr,         32'h8);

        // Test 3: redirect in WAIT, 3-cycle memory
        lat = 3;
        do_reset();
        rst = 1'b0;
        #1;
        check("t3_c0_addr", imem_addr, 32'h0);
        step(); // cycle 1, WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step(); // cycle 2, SQUASH
        redirect_valid = 1'b0;
        check("t3_sq_req",   {31'b0, imem_req},    32'd0);
        check("t3_sq_valid", {31'b0, instr_valid}, 32'd0);
        step(); // cycle 3, stale response arrives
        check("t3_sq2_valid", {31'b0, instr_valid}, 32'd0);
        step(); // cycle 4
        check("t3_req",  {31'b0, imem_req}, 32'd1);
        check("t3_addr", imem_addr,         32'h40);
        wait_valid("t3_deliver", 10);
        check("t3_pc",    pc_out,    32'h40);
        check("t3_instr", instr_out, 32'h0000_4013);

        // Test 4: redirect in HOLD coincident with handshake
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("t4_req",   {31'b0, imem_req},    32'd1);
        check("t4_addr",  imem_addr,            32'h100);
        check("t4_valid", {31'b0, instr_valid}, 32'd0);
        step();
        check("t4_no_repr", {31'b0, instr_valid}, 32'd0);
        wait_valid("t4_deliver", 10);
        check("t4_pc",    pc_out,    32'h100);
        check("t4_instr", instr_out, 32'h0001_0013);

        // Test 5: misaligned redirect -> FAULT, then recover via rst
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        check("t5_fault", {31'b0, fetch_fault}, 32'd1);
        check("t5_valid", {31'b0, instr_valid}, 32'd0);
        redirect_pc = 32'h200;   // aligned, must be ignored in FAULT
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) reqs++;
            if (i == 2) redirect_valid = 1'b0;
            step();
        end
        check("t5_no_req",    reqs,                 32'd0);
        check("t5_fault_hold",{31'b0, fetch_fault}, 32'd1);
        check("t5_valid_hold",{31'b0, instr_valid}, 32'd0);
        lat = 1;
        do_reset();
        check("t5_rst_fault", {31'b0, fetch_fault}, 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rst_req",  {31'b0, imem_req}, 32'd1);
        check("t5_rst_addr", imem_addr,         32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
